// File: rtl/pipe_em_stage.sv
// EX/MEM stage register: carries WB/MEM control, ALU result, store data and rd from EX to MEM.
// One-cycle latency; stalls on !out_ready, with SKID=1 absorbing one extra beat behind a registered in_ready.
module pipe_em_stage #(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic [DATA_W-1:0] ealu,
    input  logic [DATA_W-1:0] eb,
    input  logic [RN_W-1:0]   ern,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mb,
    output logic [RN_W-1:0]   mrn,
    output logic              skid_full,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] b;
        logic [RN_W-1:0]   rn;
    } beat_t;

    beat_t             in_dat;
    beat_t             main_q;
    beat_t             skid_q;
    beat_t             main_d;
    beat_t             skid_d;
    logic              main_vld;
    logic              skid_vld;
    logic              main_vld_d;
    logic              skid_vld_d;
    logic              rdy_q;
    logic              acc;
    logic              dlv;
    logic [CNT_W-1:0]  cnt_q;

    assign in_dat = '{wreg: ewreg, m2reg: em2reg, wmem: ewmem, alu: ealu, b: eb, rn: ern};

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready  = rdy_q;
            assign skid_full = skid_vld;
        end else begin : g_noskid
            assign in_ready  = !main_vld | out_ready;
            assign skid_full = 1'b0;
        end
    endgenerate

    assign acc = in_valid & in_ready;
    assign dlv = main_vld & out_ready;

    // With SKID=0 an accept into a full main implies a delivery, so the skid branch is unreachable.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld;
        skid_vld_d = skid_vld;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (dlv && skid_vld) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
        end else if (acc && (!main_vld || dlv)) begin
            main_d     = in_dat;
            main_vld_d = 1'b1;
        end else if (acc && SKID != 0) begin
            skid_d     = in_dat;
            skid_vld_d = 1'b1;
        end else if (dlv) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
            cnt_q    <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_vld <= main_vld_d;
            skid_vld <= skid_vld_d;
            rdy_q    <= !skid_vld_d;
            if (main_vld && !out_ready && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Control bits are gated so a bubble can never write the register file or memory.
    assign out_valid = main_vld;
    assign mwreg     = main_q.wreg  & main_vld;
    assign mm2reg    = main_q.m2reg & main_vld;
    assign mwmem     = main_q.wmem  & main_vld;
    assign malu      = main_q.alu;
    assign mb        = main_q.b;
    assign mrn       = main_q.rn;
    assign stall_cnt = cnt_q;

endmodule
